// File: rtl/irq_pkg.sv
// Shared constants for the interrupt controller: register offsets inside the
// 8-byte bus window and the 2-bit route codes.
package irq_pkg;

    localparam logic [2:0] OFF_PENDING  = 3'd0;
    localparam logic [2:0] OFF_ENABLE   = 3'd1;
    localparam logic [2:0] OFF_CLEAR    = 3'd2;
    localparam logic [2:0] OFF_ROUTE_LO = 3'd3;
    localparam logic [2:0] OFF_ROUTE_HI = 3'd4;
    localparam logic [2:0] OFF_VECTOR   = 3'd5;

    localparam logic [1:0] ROUTE_L0  = 2'd0;
    localparam logic [1:0] ROUTE_L1  = 2'd1;
    localparam logic [1:0] ROUTE_L2  = 2'd2;
    localparam logic [1:0] ROUTE_OFF = 2'd3;

endpackage

// File: rtl/irq_prio_enc.sv
// Lowest-index-first priority encoder used to build the VECTOR register.
module irq_prio_enc (
    input  logic [7:0] req,
    output logic       valid,
    output logic [2:0] idx
);

    always_comb begin
        valid = |req;
        idx   = 3'd0;
        // Scanning downward lets the lowest set bit overwrite any higher one.
        for (int i = 7; i >= 0; i--) begin
            if (req[i]) begin
                idx = 3'(i);
            end
        end
    end

endmodule

// File: rtl/irq_controller.sv
// Memory-mapped interrupt controller: latches request edges, masks and routes
// them onto three cpu interrupt lines, with a registered-read bus interface.
module irq_controller
    import irq_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR = 16'hFF00,
    parameter int          NUM_SRC   = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_SRC-1:0] irq_src,
    input  logic [15:0]        dMemIOAddress,
    input  logic [7:0]         dMemIOIn,
    input  logic               dMemIOWriteEn,
    input  logic               dMemIOReadEn,
    output logic [7:0]         irq_rdata,
    output logic               interrupt_0,
    output logic               interrupt_1,
    output logic               interrupt_2
);

    localparam logic [7:0] SRC_MASK = 8'((9'd1 << NUM_SRC) - 9'd1);

    logic [7:0]  prev_src_q, prev_src_d;
    logic [7:0]  pending_q, pending_d;
    logic [7:0]  enable_q, enable_d;
    logic [7:0]  route_lo_q, route_lo_d;
    logic [7:0]  route_hi_q, route_hi_d;
    logic [7:0]  rdata_q, rdata_d;
    logic [2:0]  int_q, int_d;

    logic [7:0]  src_ext, rise, active;
    logic [7:0]  to_l0, to_l1, to_l2;
    logic [15:0] route_all, route_mask;
    logic        in_window, wr_hit, rd_hit, vec_valid;
    logic [2:0]  offset, vec_idx;

    assign route_all = {route_hi_q, route_lo_q};
    assign in_window = (dMemIOAddress[15:3] == BASE_ADDR[15:3]);
    assign offset    = dMemIOAddress[2:0];
    assign wr_hit    = dMemIOWriteEn && in_window;
    assign rd_hit    = dMemIOReadEn && in_window;

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_src
            if (gi < NUM_SRC) begin : g_used
                assign src_ext[gi]           = irq_src[gi];
                assign route_mask[2*gi +: 2] = 2'b11;
            end else begin : g_unused
                assign src_ext[gi]           = 1'b0;
                assign route_mask[2*gi +: 2] = 2'b00;
            end
            assign active[gi] = pending_q[gi] & enable_q[gi] & (route_all[2*gi +: 2] != ROUTE_OFF);
            assign to_l0[gi]  = pending_q[gi] & enable_q[gi] & (route_all[2*gi +: 2] == ROUTE_L0);
            assign to_l1[gi]  = pending_q[gi] & enable_q[gi] & (route_all[2*gi +: 2] == ROUTE_L1);
            assign to_l2[gi]  = pending_q[gi] & enable_q[gi] & (route_all[2*gi +: 2] == ROUTE_L2);
        end
    endgenerate

    irq_prio_enc u_prio_enc (
        .req   (active),
        .valid (vec_valid),
        .idx   (vec_idx)
    );

    always_comb begin
        rise       = src_ext & ~prev_src_q;
        prev_src_d = src_ext;
        pending_d  = pending_q;
        enable_d   = enable_q;
        route_lo_d = route_lo_q;
        route_hi_d = route_hi_q;

        if (wr_hit) begin
            case (offset)
                OFF_ENABLE:   enable_d   = dMemIOIn & SRC_MASK;
                OFF_CLEAR:    pending_d  = pending_q & ~dMemIOIn;
                OFF_ROUTE_LO: route_lo_d = dMemIOIn & route_mask[7:0];
                OFF_ROUTE_HI: route_hi_d = dMemIOIn & route_mask[15:8];
                default:      ;
            endcase
        end
        // Applying the rise after the clear makes a same-cycle set win.
        pending_d = pending_d | rise;

        rdata_d = 8'h00;
        if (rd_hit) begin
            case (offset)
                OFF_PENDING:  rdata_d = pending_q;
                OFF_ENABLE:   rdata_d = enable_q;
                OFF_ROUTE_LO: rdata_d = route_lo_q;
                OFF_ROUTE_HI: rdata_d = route_hi_q;
                OFF_VECTOR:   rdata_d = vec_valid ? {1'b1, 4'b0000, vec_idx} : 8'h00;
                default:      rdata_d = 8'h00;
            endcase
        end

        int_d = {|to_l2, |to_l1, |to_l0};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_src_q <= 8'hFF;
            pending_q  <= 8'h00;
            enable_q   <= 8'h00;
            route_lo_q <= route_mask[7:0];
            route_hi_q <= route_mask[15:8];
            rdata_q    <= 8'h00;
            int_q      <= 3'b000;
        end else begin
            prev_src_q <= prev_src_d;
            pending_q  <= pending_d;
            enable_q   <= enable_d;
            route_lo_q <= route_lo_d;
            route_hi_q <= route_hi_d;
            rdata_q    <= rdata_d;
            int_q      <= int_d;
        end
    end

    assign irq_rdata   = rdata_q;
    assign interrupt_0 = int_q[0];
    assign interrupt_1 = int_q[1];
    assign interrupt_2 = int_q[2];

endmodule

// File: tb/tb_irq_controller.sv
// Bench for irq_controller: directed scenarios followed by random bus and
// request traffic, every cycle compared against a per-source behavioural model.
module tb_irq_controller;

    localparam logic [15:0] BASE = 16'hFF00;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] irq_src = 8'h00;
    logic [15:0] dMemIOAddress = 16'h0000;
    logic [7:0] dMemIOIn = 8'h00;
    logic       dMemIOWriteEn = 1'b0;
    logic       dMemIOReadEn = 1'b0;
    logic [7:0] irq_rdata;
    logic       interrupt_0, interrupt_1, interrupt_2;

    int n_checks = 0;
    int n_pass   = 0;

    // Behavioural model: one entry per source.
    bit         m_pend [8];
    bit         m_en   [8];
    bit         m_prev [8];
    int         m_rt   [8];
    logic [7:0] m_rdata;
    logic [2:0] m_int;

    irq_controller #(.BASE_ADDR(BASE), .NUM_SRC(8)) dut (
        .clk           (clk),
        .rst           (rst),
        .irq_src       (irq_src),
        .dMemIOAddress (dMemIOAddress),
        .dMemIOIn      (dMemIOIn),
        .dMemIOWriteEn (dMemIOWriteEn),
        .dMemIOReadEn  (dMemIOReadEn),
        .irq_rdata     (irq_rdata),
        .interrupt_0   (interrupt_0),
        .interrupt_1   (interrupt_1),
        .interrupt_2   (interrupt_2)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %02h, expected %02h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] model_read(input int off);
        logic [7:0] v = 8'h00;
        case (off)
            0: for (int i = 0; i < 8; i++) v[i] = m_pend[i];
            1: for (int i = 0; i < 8; i++) v[i] = m_en[i];
            3: for (int i = 0; i < 4; i++) v[2*i +: 2] = 2'(m_rt[i]);
            4: for (int i = 0; i < 4; i++) v[2*i +: 2] = 2'(m_rt[i+4]);
            5: begin
                for (int i = 7; i >= 0; i--) begin
                    if (m_pend[i] && m_en[i] && m_rt[i] != 3) v = 8'h80 + 8'(i);
                end
            end
            default: v = 8'h00;
        endcase
        return v;
    endfunction

    task automatic model_step();
        logic [7:0] rv;
        logic [2:0] iv;
        int         off;
        bit         inwin;
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                m_pend[i] = 0; m_en[i] = 0; m_prev[i] = 1; m_rt[i] = 3;
            end
            m_rdata = 8'h00;
            m_int   = 3'b000;
            return;
        end
        inwin = (int'(dMemIOAddress) >= int'(BASE)) && (int'(dMemIOAddress) < int'(BASE) + 8);
        off   = int'(dMemIOAddress) - int'(BASE);
        rv = 8'h00;
        if (dMemIOReadEn && inwin) rv = model_read(off);
        iv = 3'b000;
        for (int i = 0; i < 8; i++) begin
            if (m_pend[i] && m_en[i] && m_rt[i] < 3) iv[m_rt[i]] = 1'b1;
        end
        if (dMemIOWriteEn && inwin) begin
            case (off)
                1: for (int i = 0; i < 8; i++) m_en[i] = dMemIOIn[i];
                2: for (int i = 0; i < 8; i++) if (dMemIOIn[i]) m_pend[i] = 0;
                3: for (int i = 0; i < 4; i++) m_rt[i] = int'(dMemIOIn[2*i +: 2]);
                4: for (int i = 0; i < 4; i++) m_rt[i+4] = int'(dMemIOIn[2*i +: 2]);
                default: ;
            endcase
        end
        for (int i = 0; i < 8; i++) begin
            if (irq_src[i] && !m_prev[i]) m_pend[i] = 1;
            m_prev[i] = irq_src[i];
        end
        m_rdata = rv;
        m_int   = iv;
    endtask

    // One clock: model advances on the edge, outputs compared 1 time unit later,
    // then single-cycle strobes are released.
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check("rdata", irq_rdata, m_rdata);
        check("irq_lines", {5'b0, interrupt_2, interrupt_1, interrupt_0}, {5'b0, m_int});
        dMemIOWriteEn = 1'b0;
        dMemIOReadEn  = 1'b0;
        rst           = 1'b0;
    endtask

    task automatic wr(input int off, input logic [7:0] d);
        dMemIOAddress = BASE + 16'(off);
        dMemIOIn      = d;
        dMemIOWriteEn = 1'b1;
        tick();
    endtask

    task automatic rd_chk(input string tag, input int off, input logic [7:0] exp);
        dMemIOAddress = BASE + 16'(off);
        dMemIOReadEn  = 1'b1;
        tick();
        check(tag, irq_rdata, exp);
    endtask

    task automatic lines_chk(input string tag, input logic [2:0] exp);
        check(tag, {5'b0, interrupt_2, interrupt_1, interrupt_0}, {5'b0, exp});
    endtask

    initial begin
        // Reset and register reset values.
        rst = 1'b1; tick();
        rst = 1'b1; tick();
        rd_chk("rst_pending", 0, 8'h00);
        rd_chk("rst_enable", 1, 8'h00);
        rd_chk("rst_clear", 2, 8'h00);
        rd_chk("rst_route_lo", 3, 8'hFF);
        rd_chk("rst_route_hi", 4, 8'hFF);
        rd_chk("rst_vector", 5, 8'h00);
        lines_chk("rst_lines", 3'b000);

        // Basic edge on source 2 routed to line 1.
        wr(1, 8'h04);
        wr(3, 8'hDF);
        irq_src[2] = 1'b1;
        tick();
        lines_chk("edge_t1", 3'b000);
        tick();
        lines_chk("edge_t2", 3'b010);
        rd_chk("edge_pending", 0, 8'h04);

        // Acknowledge: line drops one cycle after the clear; held level does not re-latch.
        wr(2, 8'h04);
        lines_chk("ack_same", 3'b010);
        tick();
        lines_chk("ack_drop", 3'b000);
        rd_chk("ack_pending", 0, 8'h00);

        // Masked pending on source 5, then enabled.
        wr(1, 8'h00);
        wr(4, 8'hF3);
        irq_src[5] = 1'b1;
        tick();
        tick();
        rd_chk("masked_pending", 0, 8'h20);
        lines_chk("masked_lines", 3'b000);
        wr(1, 8'h20);
        tick();
        lines_chk("enabled_lines", 3'b001);
        rd_chk("enabled_vector", 5, 8'h85);

        // Set-wins collision on source 3.
        wr(2, 8'h20);
        irq_src[3] = 1'b1; tick();
        irq_src[3] = 1'b0; tick();
        rd_chk("coll_before", 0, 8'h08);
        irq_src[3] = 1'b1;
        wr(2, 8'h08);
        rd_chk("coll_after", 0, 8'h08);

        // Reset mid-operation with sources 1 and 6 on lines 0 and 2.
        wr(2, 8'hFF);
        wr(1, 8'h42);
        wr(3, 8'hF3);
        wr(4, 8'hEF);
        irq_src[1] = 1'b1;
        irq_src[6] = 1'b1;
        tick();
        tick();
        lines_chk("pre_rst_lines", 3'b101);
        rst = 1'b1; tick();
        lines_chk("mid_rst_lines", 3'b000);
        tick();
        rd_chk("mid_rst_pending", 0, 8'h00);
        rd_chk("mid_rst_route_lo", 3, 8'hFF);
        rd_chk("mid_rst_route_hi", 4, 8'hFF);

        // Random traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            irq_src = irq_src ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
            if ($urandom_range(0, 9) < 8)
                dMemIOAddress = BASE + 16'($urandom_range(0, 7));
            else
                dMemIOAddress = 16'($urandom);
            dMemIOIn      = 8'($urandom);
            dMemIOWriteEn = ($urandom_range(0, 9) < 3);
            dMemIOReadEn  = ($urandom_range(0, 1) == 1);
            rst           = ($urandom_range(0, 199) == 0);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/irq_controller.md
Name: irq_controller

Overview:
- Memory-mapped interrupt controller that sits directly upstream of the cpu and drives its interrupt_0, interrupt_1 and interrupt_2 inputs.
- Latches rising edges from up to 8 peripheral request lines into a pending register.
- Masks pending requests with a per-source enable and routes each source to one of the three cpu interrupt lines.
- Software configures and acknowledges it through the dMemIO bus, with the same 1-cycle read latency as d_ram.

Parameters:
- BASE_ADDR, 16'hFF00, base address of the 8-byte register window on the dMemIO bus.
- NUM_SRC, 8, number of request inputs (1..8); unused enable, pending and route bits read 0.

Ports:
- clk  input  1  system clock; all logic rises on posedge clk.
- rst  input  1  synchronous, active-high reset.
- irq_src  input  NUM_SRC  peripheral request lines, synchronous to clk.
- dMemIOAddress  input  16  bus address.
- dMemIOIn  input  8  write data from the cpu.
- dMemIOWriteEn  input  1  write strobe.
- dMemIOReadEn  input  1  read strobe.
- irq_rdata  output  8  read data; OR-muxed into the cpu's dMemIOOut by the top level.
- interrupt_0  output  1  request to the cpu, line 0.
- interrupt_1  output  1  request to the cpu, line 1.
- interrupt_2  output  1  request to the cpu, line 2.

Behaviour:
- Register map, offsets from BASE_ADDR:
  - 0 PENDING: read-only.
  - 1 ENABLE: read/write.
  - 2 CLEAR: write-1-to-clear pending; reads 0.
  - 3 ROUTE_LO: 2 bits per source, sources 0-3; source 0 in bits 1:0.
  - 4 ROUTE_HI: sources 4-7.
  - 5 VECTOR: read-only.
  - 6, 7: reserved; read 0, writes ignored.
- Route codes: 0, 1 and 2 select interrupt_0, interrupt_1 or interrupt_2; 3 means masked.
- Reset values: pending 0, enable 0, route 8'hFF in both route registers, prev_src all-ones, irq_rdata 0, interrupt_0..2 all 0.
- Edge detect: rise = irq_src & ~prev_src, and prev_src <= irq_src every cycle.
  - Because prev_src resets to all-ones, a line already high at reset release does not latch.
- Pending is set on rise regardless of enable or route. A source pending while disabled asserts its output once it is enabled.
- Clear: on a write to offset 2, pending <= (pending & ~dMemIOIn) | rise. If a rise and a clear hit the same bit in the same cycle, set wins.
- Writes take effect at the clock edge where dMemIOWriteEn is high and the address matches the window.
- Reads: when dMemIOReadEn is high and the address is in the window, irq_rdata is registered and valid the next cycle.
  - Otherwise irq_rdata is 0 the next cycle, so it can be OR-muxed.
  - A read returns register contents from before any same-cycle update.
- If dMemIOReadEn and dMemIOWriteEn are both asserted, both are honoured; the read returns the pre-write value.
- VECTOR: bit7 = valid, bits 2:0 = lowest-index source with pending & enable & route != 3. Reads 8'h00 when no such source exists.
- Outputs: interrupt_n is registered and equals the OR over sources of (pending & enable & route == n).
  - Latency: edge on irq_src at cycle t, pending set at t+1, interrupt_n high at t+2.
  - The line stays high until it is cleared, disabled or rerouted; it drops 1 cycle after the write takes effect.
- Addresses outside the window are ignored entirely.
- rst asserted mid-operation: all state returns to reset values at the next edge; no interrupt is retained.

Decomposition:
- Shared package irq_pkg holds:
  - register offsets (OFF_PENDING=0, OFF_ENABLE=1, OFF_CLEAR=2, OFF_ROUTE_LO=3, OFF_ROUTE_HI=4, OFF_VECTOR=5);
  - route codes (ROUTE_L0=0, ROUTE_L1=1, ROUTE_L2=2, ROUTE_OFF=3).
- One natural sub-module: irq_prio_enc, a combinational lowest-index-first encoder producing the VECTOR valid bit and index.
- Edge detection, the register file and output routing stay in irq_controller.

Test Plan:
- Reset check: rst high for 2 cycles, then read offsets 0-5 -> 00, 00, 00, FF, FF, 00; all interrupt lines 0.
- Basic edge: write ENABLE=8'h04, ROUTE_LO=8'hDF (source 2 routed to line 1), then pulse irq_src[2] 0->1 at cycle t -> PENDING reads 04, interrupt_1 high at t+2, interrupt_0 and interrupt_2 remain 0.
- Acknowledge: write CLEAR=8'h04 -> interrupt_1 low 1 cycle after the write; PENDING reads 00; irq_src[2] held high causes no re-latch.
- Masked pending: with ENABLE=0, raise irq_src[5] with ROUTE_HI=8'hF3 (source 5 on line 0) -> PENDING=20, interrupt_0 stays 0. Then write ENABLE=8'h20 -> interrupt_0 high 1 cycle later; VECTOR reads 85.
- Set-wins collision: with bit 3 pending, write CLEAR=8'h08 in the same cycle as a new rise on irq_src[3] -> PENDING still reads 08.
- Reset mid-operation: with sources 1 and 6 pending and interrupt_0 and interrupt_2 high, assert rst for 1 cycle -> all outputs 0 on the next edge, PENDING=00, ROUTE=FF; irq_src held high causes no new pending.
